div3_scheduler: RTL and testbench

Shares one pipelined divide-by-3 datapath among NREQ requesters. A round-robin arbiter issues at most one operand per cycle into the divider. A tag pipeline tracks which requester owns each in-flight operand, and each result is routed back to its owner. The block sits between the requester blocks and a single `divide_by_3` instance, whose valid-only pipeline has no ready and no tags.

---
 rtl/div3_scheduler.sv | 147 ++++++++++++++
 tb/tb_div3_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div3_scheduler.sv
// rtl/div3_scheduler.sv - round-robin scheduler sharing one pipelined divide-by-3 unit among NREQ requesters
module div3_scheduler #(
    parameter int DWIDTH      = 8,
    parameter int NREQ        = 4,
    parameter int DIV_LATENCY = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_en,
    input  logic [NREQ-1:0]          i_req,
    input  logic [NREQ*DWIDTH-1:0]   i_req_dat,
    output logic [NREQ-1:0]          o_req_ack,
    output logic [DWIDTH-1:0]        o_div_n,
    output logic                     o_div_n_valid,
    input  logic [DWIDTH-1:0]        i_div3,
    input  logic                     i_div3_valid,
    output logic [NREQ-1:0]          o_rsp_valid,
    output logic [DWIDTH-1:0]        o_rsp_dat,
    output logic                     o_busy,
    output logic                     o_idle,
    output logic                     o_err
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(DIV_LATENCY + 2);

    typedef enum logic {
        ST_DRAIN = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                       state;
    state_t                       state_nxt;
    logic                         grant_en;
    logic [IW-1:0]                rr_ptr;
    logic [NREQ-1:0]              eligible;
    logic [IW:0]                  scan_idx;
    logic                         grant;
    logic [IW-1:0]                grant_id;
    logic [IW-1:0]                issue_id;
    logic [DIV_LATENCY-1:0]       tag_v;
    logic [DIV_LATENCY-1:0][IW-1:0] tag_id;
    logic                         tail_v;
    logic [IW-1:0]                tail_id;
    logic [CW-1:0]                inflight;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_DRAIN;
        end else begin
            state <= state_nxt;
        end
    end

    // A grant needs both RUN and a live i_en, so dropping i_en blocks the grant in that same cycle
    always_comb begin
        state_nxt = state;
        grant_en  = 1'b0;
        o_idle    = 1'b0;
        case (state)
            ST_RUN: begin
                if (!i_en) begin
                    state_nxt = ST_DRAIN;
                end else begin
                    grant_en = 1'b1;
                end
            end
            ST_DRAIN: begin
                o_idle = (inflight == '0);
                if (i_en) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_DRAIN;
        endcase
    end

    always_comb begin
        eligible = i_req & ~o_req_ack;
        grant    = 1'b0;
        grant_id = '0;
        scan_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = {1'b0, rr_ptr} + (IW+1)'(i);
            if (scan_idx >= (IW+1)'(NREQ)) begin
                scan_idx = scan_idx - (IW+1)'(NREQ);
            end
            if (!grant && grant_en && eligible[scan_idx[IW-1:0]]) begin
                grant    = 1'b1;
                grant_id = scan_idx[IW-1:0];
            end
        end
    end

    // The issue register (o_div_n_valid, issue_id) is the tag head; the pipe below lines its tail up with the divider output
    assign tail_v  = tag_v[DIV_LATENCY-1];
    assign tail_id = tag_id[DIV_LATENCY-1];
    assign o_busy  = (inflight != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr        <= '0;
            o_req_ack     <= '0;
            o_div_n       <= '0;
            o_div_n_valid <= 1'b0;
            issue_id      <= '0;
            tag_v         <= '0;
            tag_id        <= '0;
            o_rsp_valid   <= '0;
            o_rsp_dat     <= '0;
            o_err         <= 1'b0;
            inflight      <= '0;
        end else begin
            o_req_ack     <= '0;
            o_div_n_valid <= grant;
            if (grant) begin
                o_req_ack <= NREQ'(1) << grant_id;
                o_div_n   <= i_req_dat[grant_id*DWIDTH +: DWIDTH];
                issue_id  <= grant_id;
                rr_ptr    <= (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);
            end

            tag_v[0]  <= o_div_n_valid;
            tag_id[0] <= issue_id;
            for (int i = 1; i < DIV_LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end

            o_rsp_valid <= '0;
            if (tail_v && i_div3_valid) begin
                o_rsp_valid <= NREQ'(1) << tail_id;
                o_rsp_dat   <= i_div3;
            end
            if (tail_v != i_div3_valid) begin
                o_err <= 1'b1;
            end

            case ({grant, tail_v})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_div3_scheduler.sv
// tb/tb_div3_scheduler.sv - randomized bench for div3_scheduler against a transaction-level reference model
module tb_div3_scheduler;

    localparam int DW  = 8;
    localparam int NR  = 4;
    localparam int LAT = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               i_en = 1'b0;
    logic [NR-1:0]      i_req = '0;
    logic [NR*DW-1:0]   i_req_dat = '0;
    logic [NR-1:0]      o_req_ack;
    logic [DW-1:0]      o_div_n;
    logic               o_div_n_valid;
    logic [DW-1:0]      i_div3 = '0;
    logic               i_div3_valid = 1'b0;
    logic [NR-1:0]      o_rsp_valid;
    logic [DW-1:0]      o_rsp_dat;
    logic               o_busy;
    logic               o_idle;
    logic               o_err;

    div3_scheduler #(.DWIDTH(DW), .NREQ(NR), .DIV_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .i_en(i_en), .i_req(i_req), .i_req_dat(i_req_dat),
        .o_req_ack(o_req_ack), .o_div_n(o_div_n), .o_div_n_valid(o_div_n_valid),
        .i_div3(i_div3), .i_div3_valid(i_div3_valid),
        .o_rsp_valid(o_rsp_valid), .o_rsp_dat(o_rsp_dat),
        .o_busy(o_busy), .o_idle(o_idle), .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct { int owner; int res; int tail; } flight_t;
    typedef struct { bit v; int n; } obs_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    flight_t    fq[$];
    obs_t       dq[$];
    bit         m_run;
    int         m_ptr;
    logic [NR-1:0] e_ack, e_rsp;
    logic [DW-1:0] e_n, e_rdat;
    logic       e_dv, e_busy, e_idle, e_err;
    int         want[NR];
    int         fixed_op[NR];
    bit         rand_mode = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        dq.delete();
        m_run = 1'b0; m_ptr = 0;
        e_ack = '0; e_rsp = '0; e_n = '0; e_rdat = '0;
        e_dv = 1'b0; e_busy = 1'b0; e_idle = 1'b1; e_err = 1'b0;
    endtask

    // Predicts what the block shows next cycle from the inputs currently driven
    task automatic predict();
        int w;
        bit tv;
        if (rst) begin
            model_reset();
            return;
        end
        w = -1;
        if (m_run && i_en) begin
            for (int i = 0; i < NR; i++) begin
                automatic int k = (m_ptr + i) % NR;
                if (w < 0 && i_req[k] && !e_ack[k]) w = k;
            end
        end
        tv = (fq.size() > 0) && (fq[0].tail == cyc);
        e_rsp = '0;
        if (tv && i_div3_valid) begin
            e_rsp[fq[0].owner] = 1'b1;
            e_rdat = DW'(fq[0].res);
        end else if (tv != i_div3_valid) begin
            e_err = 1'b1;
        end
        if (tv) void'(fq.pop_front());
        e_ack = '0;
        e_dv  = 1'b0;
        if (w >= 0) begin
            e_ack[w] = 1'b1;
            e_dv = 1'b1;
            e_n = i_req_dat[w*DW +: DW];
            fq.push_back('{w, int'(e_n) / 3, cyc + 1 + LAT});
            m_ptr = (w + 1) % NR;
        end
        m_run  = i_en;
        e_busy = (fq.size() != 0);
        e_idle = !m_run && (fq.size() == 0);
    endtask

    task automatic compare();
        chk("ack", 32'(o_req_ack), 32'(e_ack));
        chk("ack_onehot0", 32'($onehot0(o_req_ack)), 32'd1);
        chk("div_n_valid", 32'(o_div_n_valid), 32'(e_dv));
        chk("div_n", 32'(o_div_n), 32'(e_n));
        chk("rsp_valid", 32'(o_rsp_valid), 32'(e_rsp));
        if (e_rsp != '0) chk("rsp_dat", 32'(o_rsp_dat), 32'(e_rdat));
        if (rst) chk("rsp_dat_rst", 32'(o_rsp_dat), 32'd0);
        chk("busy", 32'(o_busy), 32'(e_busy));
        chk("idle", 32'(o_idle), 32'(e_idle));
        chk("err", 32'(o_err), 32'(e_err));
    endtask

    // Behavioural divider: fixed LAT-cycle delay of (valid, n/3)
    task automatic drive_divider();
        obs_t o;
        i_div3_valid = 1'b0;
        i_div3 = '0;
        if (rst) begin
            dq.delete();
            return;
        end
        dq.push_back('{o_div_n_valid, int'(o_div_n)});
        if (dq.size() > LAT) begin
            o = dq.pop_front();
            i_div3_valid = o.v;
            i_div3 = DW'(o.n / 3);
        end
    endtask

    task automatic drive_reqs();
        for (int k = 0; k < NR; k++) begin
            if (o_req_ack[k]) begin
                if (want[k] > 0) want[k]--;
                i_req[k] = 1'b0;
            end
            if (!i_req[k]) begin
                if (rand_mode) begin
                    if ($urandom_range(0, 2) == 0) begin
                        i_req[k] = 1'b1;
                        i_req_dat[k*DW +: DW] = DW'($urandom);
                    end
                end else if (want[k] > 0) begin
                    i_req[k] = 1'b1;
                    i_req_dat[k*DW +: DW] = DW'(fixed_op[k]);
                end
            end
        end
    endtask

    task automatic tick();
        predict();
        @(negedge clk);
        cyc++;
        compare();
        drive_divider();
        drive_reqs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_until_acks(input int n, input int budget);
        int seen;
        seen = 0;
        for (int i = 0; i < budget && seen < n; i++) begin
            tick();
            seen += $countones(o_req_ack);
        end
        chk("ack_budget", 32'(seen), 32'(n));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_req = '0;
        for (int k = 0; k < NR; k++) want[k] = 0;
        #1;
        chk("async_ack", 32'(o_req_ack), 32'd0);
        chk("async_dv", 32'(o_div_n_valid), 32'd0);
        chk("async_div_n", 32'(o_div_n), 32'd0);
        chk("async_rsp", 32'(o_rsp_valid), 32'd0);
        chk("async_rsp_dat", 32'(o_rsp_dat), 32'd0);
        chk("async_busy", 32'(o_busy), 32'd0);
        chk("async_idle", 32'(o_idle), 32'd1);
        chk("async_err", 32'(o_err), 32'd0);
        run(2);
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        model_reset();
        for (int k = 0; k < NR; k++) begin
            want[k] = 0;
            fixed_op[k] = 3 * (k + 1);
        end
        run(2);
        rst = 1'b0;
        i_en = 1'b1;

        // single requester 0 sends 9
        fixed_op[0] = 9;
        want[0] = 1;
        run_until_acks(1, 20);
        run(LAT + 4);

        // all four requesters with operands 3, 6, 9, 12
        do_reset();
        fixed_op[0] = 3;
        for (int k = 0; k < NR; k++) want[k] = 3;
        run_until_acks(12, 40);
        run(LAT + 4);

        // requesters 1 and 3 after the pointer has moved to 2
        do_reset();
        want[1] = 1;
        run_until_acks(1, 20);
        want[1] = 2;
        want[3] = 2;
        run_until_acks(4, 30);
        run(LAT + 4);

        // drain with three operations in flight, then resume
        want[0] = 1; want[1] = 2; want[2] = 1; want[3] = 3;
        run_until_acks(3, 20);
        i_en = 1'b0;
        run(LAT + 8);
        i_en = 1'b1;
        run_until_acks(4, 30);
        run(LAT + 4);

        // random traffic with i_en toggling
        rand_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) i_en = ~i_en;
            tick();
        end
        rand_mode = 1'b0;
        i_en = 1'b1;
        run(30);

        // spurious divider valid with no tag in flight
        i_div3_valid = 1'b1;
        i_div3 = 8'h55;
        run(6);

        // reset with two operations in flight
        want[0] = 1;
        want[2] = 1;
        run_until_acks(2, 20);
        do_reset();
        run(LAT + 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
